tick_sequencer: RTL and testbench
=================================

Name: tick_sequencer

Overview:
Run controller for a tick-driven shift datapath. It owns a runtime rate-selectable divider and emits exactly STEPS single-cycle shift_en pulses per run. Runs are started, paused, resumed and aborted by single-cycle control pulses from debounced buttons. The block sits between the button front-end and the shift register, replacing a free-running fixed-rate tick.

Parameters:
CLOCK_FREQ, 100_000_000, input clock frequency in Hz
BASE_HZ, 2, tick rate in Hz for rate_sel = 0
STEPS, 8, shift_en pulses per run (>= 1)

Ports:
clk  input  1  system clock; single clock domain
rst_n  input  1  reset; synchronous, active-low
start  input  1  single-cycle pulse; begin a run
pause  input  1  single-cycle pulse; toggles RUN <-> PAUSED
abort  input  1  single-cycle pulse; cancel the run
rate_sel  input  2  tick rate = BASE_HZ << rate_sel
shift_en  output  1  single-cycle tick to the datapath
step  output  clog2(STEPS+1)  pulses issued in the current or last run
busy  output  1  high in RUN or PAUSED
paused  output  1  high in PAUSED
done  output  1  single-cycle completion pulse

Behaviour:
- All outputs are registered. LIMIT(r) = CLOCK_FREQ / (BASE_HZ << r). MAX(r) = LIMIT(r) - 1.
- Counter width is clog2(LIMIT(0)). LIMIT(3) >= 2 is required; elaboration fails otherwise.
- Reset (rst_n = 0 at a clk edge): state = IDLE; counter, rate_q, shift_en, step, done, busy and paused are all 0. Reset overrides every input.
- States: IDLE, RUN, PAUSED, DONE.
- Priority per edge: reset > abort > terminal tick > pause > start.
- IDLE, start = 1:
  - Go to RUN; counter = 0; step = 0; rate_q = rate_sel.
  - start and abort in the same cycle: remain IDLE.
- RUN, each edge:
  - counter == MAX(rate_q): shift_en <= 1, counter <= 0, step <= step + 1, rate_q <= rate_sel. A new rate therefore applies only from the next tick interval.
  - Otherwise: shift_en <= 0, counter <= counter + 1.
  - First shift_en is high in the cycle beginning LIMIT edges after the start edge.
- Terminal tick (the tick making step == STEPS): go to DONE and set done <= 1 on the same edge, coincident with the final shift_en.
  - A pause in that cycle is ignored.
  - Any other tick coinciding with pause: the tick is still issued, then the state goes to PAUSED.
- RUN, pause = 1 with no tick due: go to PAUSED; counter holds on that edge.
- PAUSED:
  - counter, step and rate_q hold; shift_en = 0.
  - pause = 1: go to RUN; counter holds on that edge.
  - start is ignored.
- DONE: lasts exactly one cycle, then IDLE with done <= 0. start in DONE is ignored.
- Abort in RUN or PAUSED: next state IDLE; shift_en, done, busy and paused are 0; step = 0; counter = 0. No done pulse is issued.
- start while RUN, PAUSED or DONE: ignored.
- busy = (state in {RUN, PAUSED}). paused = (state == PAUSED).
- step holds STEPS through DONE and IDLE until the next start clears it.
- shift_en never asserts outside RUN or the terminal tick edge, and never for two consecutive cycles.

Test Plan:
All scenarios use CLOCK_FREQ = 16, BASE_HZ = 1, STEPS = 4, giving LIMIT = 16 / 8 / 4 / 2 for rate_sel 0..3. Edge E0 is the start edge.

1. Reset: hold rst_n = 0 for 3 cycles with start = 1 and pause = 1 -> all outputs 0; after release with inputs low, busy stays 0.
2. Basic run: rate_sel = 2, start at E0 -> shift_en high exactly in the cycles after E4, E8, E12 and E16; step = 1, 2, 3, 4; done high only with the 4th pulse; busy = 0 from E17; step holds 4.
3. Pause and resume: rate_sel = 1, pause at E5, pause again at E15 -> paused = 1 from E5 to E15; first shift_en after E19; no shift_en while paused.
4. Abort mid-run: rate_sel = 3, abort sampled at E5 (after two pulses) -> at E5 busy = 0 and step = 0; no done; no shift_en for 20 further cycles. Also start + abort in the same IDLE cycle -> busy stays 0.
5. Rate change: rate_sel = 0 at start, switched to 3 at E3 -> first pulse after E16, then pulses after E18, E20 and E22.
6. Corner cases:
   - start pulsed at E2 while RUN -> no restart; pulse timing unchanged.
   - pause coincident with the terminal tick -> done = 1, paused stays 0, IDLE next cycle.
   - pause coincident with a non-terminal tick -> shift_en issued, then paused = 1.

Source files
------------

// File: rtl/tick_sequencer.sv
// Run controller: rate-selectable tick divider issuing STEPS shift_en pulses
// per run, with start / pause-toggle / abort control pulses.
module tick_sequencer #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BASE_HZ    = 2,
    parameter int STEPS      = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             pause,
    input  logic                             abort,
    input  logic [1:0]                       rate_sel,
    output logic                             shift_en,
    output logic [$clog2(STEPS+1)-1:0]       step,
    output logic                             busy,
    output logic                             paused,
    output logic                             done
);

    localparam int LIMIT0 = CLOCK_FREQ / BASE_HZ;
    localparam int LIMIT1 = CLOCK_FREQ / (BASE_HZ << 1);
    localparam int LIMIT2 = CLOCK_FREQ / (BASE_HZ << 2);
    localparam int LIMIT3 = CLOCK_FREQ / (BASE_HZ << 3);
    localparam int CW     = $clog2(LIMIT0);
    localparam int SW     = $clog2(STEPS + 1);

    localparam logic [CW-1:0] MAX0 = CW'(LIMIT0 - 1);
    localparam logic [CW-1:0] MAX1 = CW'(LIMIT1 - 1);
    localparam logic [CW-1:0] MAX2 = CW'(LIMIT2 - 1);
    localparam logic [CW-1:0] MAX3 = CW'(LIMIT3 - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    generate
        if (LIMIT3 < 2) begin : g_bad_rate
            $error("tick_sequencer: fastest tick interval must be >= 2 cycles");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] step_q, step_d;
    logic [1:0]    rate_q, rate_d;
    logic          shift_q, shift_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          paused_q, paused_d;
    logic [CW-1:0] max_cnt;
    logic          tick;
    logic          last;

    always_comb begin
        max_cnt = MAX0;
        unique case (rate_q)
            2'd0: max_cnt = MAX0;
            2'd1: max_cnt = MAX1;
            2'd2: max_cnt = MAX2;
            2'd3: max_cnt = MAX3;
        endcase
    end

    assign tick = (cnt_q == max_cnt);
    assign last = (step_q == SW'(STEPS - 1));

    // Abort outranks the tick; the terminal tick outranks pause.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        rate_d  = rate_q;
        shift_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    step_d  = '0;
                    rate_d  = rate_sel;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    step_d  = '0;
                end else if (tick) begin
                    shift_d = 1'b1;
                    cnt_d   = '0;
                    step_d  = step_q + SW'(1);
                    rate_d  = rate_sel;
                    if (last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (pause) begin
                        state_d = S_PAUSED;
                    end
                end else if (pause) begin
                    state_d = S_PAUSED;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PAUSED: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    step_d  = '0;
                end else if (pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d   = (state_d == S_RUN) || (state_d == S_PAUSED);
        paused_d = (state_d == S_PAUSED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            rate_q   <= '0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            rate_q   <= rate_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            paused_q <= paused_d;
        end
    end

    assign shift_en = shift_q;
    assign step     = step_q;
    assign busy     = busy_q;
    assign paused   = paused_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed bench for tick_sequencer with CLOCK_FREQ=16, BASE_HZ=1, STEPS=4
// (tick interval 16/8/4/2 cycles for rate_sel 0..3).
module tb_tick_sequencer;

    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          pause;
    logic          abort;
    logic [1:0]    rate_sel;
    logic          shift_en;
    logic [SW-1:0] step;
    logic          busy;
    logic          paused;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    tick_sequencer #(
        .CLOCK_FREQ(16),
        .BASE_HZ   (1),
        .STEPS     (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .pause   (pause),
        .abort   (abort),
        .rate_sel(rate_sel),
        .shift_en(shift_en),
        .step    (step),
        .busy    (busy),
        .paused  (paused),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One active edge, then sample 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [1:0] r);
        rate_sel = r;
        start    = 1'b1;
        cyc();
        start    = 1'b0;
    endtask

    task automatic clean_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
    endtask

    // rate 2: ticks after E4, E8, E12, E16; optional stray start at E2.
    task automatic run_basic(input bit stray, input string nm);
        bit p;
        begin_run(2'd2);
        for (int e = 1; e <= 20; e++) begin
            start = stray && (e == 2);
            cyc();
            start = 1'b0;
            p = (e == 4) || (e == 8) || (e == 12) || (e == 16);
            check({nm, "_shift_en"}, int'(shift_en), int'(p));
            check({nm, "_done"}, int'(done), int'(e == 16));
            if (p) check({nm, "_step"}, int'(step), e / 4);
            if (e >= 17) begin
                check({nm, "_busy_end"}, int'(busy), 0);
                check({nm, "_step_hold"}, int'(step), 4);
            end else begin
                check({nm, "_busy_run"}, int'(busy), int'(e < 16));
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        pause    = 1'b1;
        abort    = 1'b0;
        rate_sel = 2'd0;

        // Reset overrides start/pause
        repeat (3) cyc();
        check("rst_shift_en", int'(shift_en), 0);
        check("rst_step", int'(step), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_paused", int'(paused), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        cyc();
        cyc();
        check("post_rst_busy", int'(busy), 0);

        run_basic(1'b0, "basic");
        cyc();
        run_basic(1'b1, "stray_start");
        cyc();

        // Pause at E5, resume at E15, first tick after E19
        begin_run(2'd1);
        for (int e = 1; e <= 22; e++) begin
            pause = (e == 5) || (e == 15);
            cyc();
            pause = 1'b0;
            check("pr_paused", int'(paused), int'(e >= 5 && e < 15));
            check("pr_shift_en", int'(shift_en), int'(e == 19));
            check("pr_busy", int'(busy), 1);
        end
        check("pr_step", int'(step), 1);
        clean_abort();
        check("pr_abort_busy", int'(busy), 0);

        // Abort at E5 after two ticks
        begin_run(2'd3);
        for (int e = 1; e <= 25; e++) begin
            abort = (e == 5);
            cyc();
            abort = 1'b0;
            if (e < 5) begin
                check("ab_shift_en", int'(shift_en), int'(e == 2 || e == 4));
            end else begin
                check("ab_shift_off", int'(shift_en), 0);
                check("ab_done", int'(done), 0);
                check("ab_busy", int'(busy), 0);
                check("ab_step", int'(step), 0);
            end
        end
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy0", int'(busy), 0);
        cyc();
        check("sa_busy1", int'(busy), 0);

        // Rate change 0 -> 3 at E3 takes effect after the first tick
        begin_run(2'd0);
        for (int e = 1; e <= 24; e++) begin
            if (e == 3) rate_sel = 2'd3;
            cyc();
            check("rc_shift_en", int'(shift_en),
                  int'(e == 16 || e == 18 || e == 20 || e == 22));
            check("rc_done", int'(done), int'(e == 22));
        end
        check("rc_step", int'(step), 4);

        // Pause on the terminal tick (ticks at E2,4,6,8) is ignored
        begin_run(2'd3);
        for (int e = 1; e <= 8; e++) begin
            pause = (e == 8);
            cyc();
            pause = 1'b0;
        end
        check("pt_shift_en", int'(shift_en), 1);
        check("pt_done", int'(done), 1);
        check("pt_paused", int'(paused), 0);
        cyc();
        check("pt_busy_next", int'(busy), 0);
        check("pt_paused_next", int'(paused), 0);
        check("pt_done_next", int'(done), 0);

        // Pause on a non-terminal tick: tick issued, then paused
        begin_run(2'd3);
        cyc();
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("pn_shift_en", int'(shift_en), 1);
        check("pn_step", int'(step), 1);
        cyc();
        check("pn_paused", int'(paused), 1);
        check("pn_shift_off", int'(shift_en), 0);
        pause = 1'b1;
        cyc();
        pause = 1'b0;
        check("pn_resumed", int'(paused), 0);
        cyc();
        check("pn_e5_shift", int'(shift_en), 0);
        cyc();
        check("pn_e6_shift", int'(shift_en), 1);
        check("pn_e6_step", int'(step), 2);
        clean_abort();
        check("pn_abort_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
